// File: rtl/tron_mem_bridge_if.sv
// CPU-side bus of the Tron memory bridge: request strobe, addresses and store data in,
// fetched instruction, loaded data and handshake status out.
interface tron_mem_bridge_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  cpuReq;
    logic                  fetchPhase;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] addressOut;
    logic [ADDR_WIDTH-1:0] regA;
    logic [DATA_WIDTH-1:0] busOutput;
    logic [DATA_WIDTH-1:0] instruction;
    logic [DATA_WIDTH-1:0] memData;
    logic                  ready;
    logic                  busy;
    logic                  reqDropped;

    modport master (
        output cpuReq, fetchPhase, memWrite, addressOut, regA, busOutput,
        input  instruction, memData, ready, busy, reqDropped
    );

    modport slave (
        input  cpuReq, fetchPhase, memWrite, addressOut, regA, busOutput,
        output instruction, memData, ready, busy, reqDropped
    );
endinterface

// File: rtl/tron_mem_bridge.sv
// Memory-side stage of the Tron CPU: sequences a 1-cycle-latency synchronous RAM and
// decodes a memory-mapped LED register behind a req/ready handshake.
module tron_mem_bridge #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE     = 16'hFF00,
    parameter logic [ADDR_WIDTH-1:0] LED_ADDR    = 16'hFF00,
    parameter logic [DATA_WIDTH-1:0] RESET_INSTR = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    tron_mem_bridge_if.slave      cpu,
    output logic [ADDR_WIDTH-1:0] ramAddr,
    output logic [DATA_WIDTH-1:0] ramWdata,
    output logic                  ramWe,
    input  logic [DATA_WIDTH-1:0] ramRdata,
    output logic [DATA_WIDTH-1:0] LED
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic                  accept_s;
    logic                  drop_s;
    logic                  store_s;
    logic [ADDR_WIDTH-1:0] req_addr_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0] ram_wdata_r;
    logic                  ram_we_r;
    logic                  fetch_r;
    logic [DATA_WIDTH-1:0] instr_r;
    logic [DATA_WIDTH-1:0] mem_data_r;
    logic [DATA_WIDTH-1:0] led_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  req_dropped_r;

    assign store_s    = !cpu.fetchPhase && cpu.memWrite;
    assign req_addr_s = cpu.fetchPhase ? cpu.addressOut : cpu.regA;

    // I/O reads bypass the RAM: the LED register at its address, zero elsewhere in the region.
    always_comb begin
        rd_data_s = ramRdata;
        if (ram_addr_r >= IO_BASE) begin
            if (ram_addr_r == LED_ADDR) begin
                rd_data_s = led_r;
            end else begin
                rd_data_s = {DATA_WIDTH{1'b0}};
            end
        end else begin
            rd_data_s = ramRdata;
        end
    end

    // Next-state decode; a request in DONE chains straight into the next access.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (cpu.cpuReq) begin
                    accept_s     = 1'b1;
                    next_state_s = store_s ? WRITE : READ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITE: begin
                drop_s       = cpu.cpuReq;
                next_state_s = DONE;
            end
            READ: begin
                drop_s       = cpu.cpuReq;
                next_state_s = LATCH;
            end
            LATCH: begin
                drop_s       = cpu.cpuReq;
                next_state_s = DONE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath and handshake registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_addr_r    <= {ADDR_WIDTH{1'b0}};
            ram_wdata_r   <= {DATA_WIDTH{1'b0}};
            ram_we_r      <= 1'b0;
            fetch_r       <= 1'b0;
            instr_r       <= RESET_INSTR;
            mem_data_r    <= {DATA_WIDTH{1'b0}};
            led_r         <= {DATA_WIDTH{1'b0}};
            ready_r       <= 1'b0;
            busy_r        <= 1'b0;
            req_dropped_r <= 1'b0;
        end else begin
            ready_r  <= (next_state_s == DONE);
            busy_r   <= (next_state_s == WRITE) || (next_state_s == READ) ||
                        (next_state_s == LATCH);
            ram_we_r <= accept_s && store_s && (req_addr_s < IO_BASE);
            if (drop_s) begin
                req_dropped_r <= 1'b1;
            end
            if (accept_s) begin
                ram_addr_r  <= req_addr_s;
                ram_wdata_r <= cpu.busOutput;
                fetch_r     <= cpu.fetchPhase;
            end
            if ((state_r == WRITE) && (ram_addr_r == LED_ADDR)) begin
                led_r <= ram_wdata_r;
            end
            // ramRdata is valid in LATCH, one cycle after the address was presented in READ.
            if (state_r == LATCH) begin
                if (fetch_r) begin
                    instr_r <= rd_data_s;
                end else begin
                    mem_data_r <= rd_data_s;
                end
            end
        end
    end

    assign ramAddr         = ram_addr_r;
    assign ramWdata        = ram_wdata_r;
    assign ramWe           = ram_we_r;
    assign LED             = led_r;
    assign cpu.instruction = instr_r;
    assign cpu.memData     = mem_data_r;
    assign cpu.ready       = ready_r;
    assign cpu.busy        = busy_r;
    assign cpu.reqDropped  = req_dropped_r;

endmodule
